// File: rtl/ped_request_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ped_req_pkg (package)
//  Purpose  : Shared types and helpers for the pedestrian request conditioner:
//             FSM state encoding, request-counter width, ceil-log2 helper.
//  Revision : 1.0 - initial release
// ============================================================================
package ped_req_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVICE = 2'd2,
        HOLDOFF = 2'd3
    } state_e;

    localparam int REQ_COUNT_W = 8;

    // Smallest width able to index 'value' distinct codes; never below 1 bit.
    // Used as clog2(N+1) to size a counter that must hold the value N.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ped_request_cond_if.sv
`default_nettype none
// ============================================================================
//  Module   : ped_request_cond_if
//  Purpose  : Bundles the button input, controller handshake and status
//             outputs of one request conditioner.
//  Modports : master - the conditioner (drives request/btn_clean/busy)
//             slave  - the traffic-light controller side
//  Macro    : PED_REQ_COUNT_EN adds req_count[7:0]
//  Revision : 1.0 - initial release
// ============================================================================
interface ped_request_cond_if;

    logic btn_raw;
    logic ack;
    logic request;
    logic btn_clean;
    logic busy;
`ifdef PED_REQ_COUNT_EN
    logic [ped_req_pkg::REQ_COUNT_W-1:0] req_count;

    modport master (
        input  btn_raw,
        input  ack,
        output request,
        output btn_clean,
        output busy,
        output req_count
    );

    modport slave (
        output btn_raw,
        output ack,
        input  request,
        input  btn_clean,
        input  busy,
        input  req_count
    );
`else
    modport master (
        input  btn_raw,
        input  ack,
        output request,
        output btn_clean,
        output busy
    );

    modport slave (
        output btn_raw,
        output ack,
        input  request,
        input  btn_clean,
        input  busy
    );
`endif

endinterface
`default_nettype wire

// File: rtl/ped_request_cond_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_filter
//  Purpose  : Synchronizes an asynchronous level and only lets the clean
//             output follow it after DB_CYCLES consecutive mismatched cycles.
//  Ports    : clk  - clock
//             rst  - asynchronous active-high reset
//             din  - raw asynchronous level
//             dout - debounced, registered level
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_filter
    import ped_req_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int               CNT_W    = clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   dout_q;
    logic                   dout_d;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // Counter runs only while the synchronized level disagrees with the
    // clean level; any agreement restarts the qualification window.
    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        if (btn_sync != dout_q) begin
            if (cnt_q == CNT_LAST) begin
                dout_d = ~dout_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule
`default_nettype wire

// File: rtl/ped_request_cond.sv
`default_nettype none
// ============================================================================
//  Module   : ped_request_cond
//  Purpose  : Turns a bouncing push-button into a latched service request,
//             held until acknowledged, followed by a re-trigger hold-off.
//  Ports    : clk            - board clock
//             rst            - asynchronous active-high reset
//             bus.btn_raw    - raw button (async)
//             bus.ack        - controller service acknowledge (level)
//             bus.request    - latched request (registered)
//             bus.btn_clean  - debounced button level (registered)
//             bus.busy       - high in SERVICE or HOLDOFF (registered)
//             bus.req_count  - accepted press count, saturating (optional)
//  Macro    : PED_REQ_COUNT_EN enables the req_count output and counter
//  Revision : 1.0 - initial release
// ============================================================================
module ped_request_cond
    import ped_req_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLDOFF_CYCLES = 150000000
) (
    input  logic                clk,
    input  logic                rst,
    ped_request_cond_if.master  bus
);

    localparam int              DB_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int              HO_W      = clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HO_W-1:0] HO_LOAD   = HO_W'(HOLDOFF_CYCLES - 1);

    logic            btn_clean;
    logic            clean_prev_q;
    logic            press;
    logic            ho_done;
    state_e          state_q;
    logic [HO_W-1:0] ho_cnt_q;
    logic            request_q;
    logic            busy_q;

    debounce_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.btn_raw),
        .dout (btn_clean)
    );

    // Rising edge of the clean level only; releases never request service.
    assign press   = btn_clean & ~clean_prev_q;
    assign ho_done = (state_q == HOLDOFF) && (ho_cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ho_cnt_q     <= '0;
            request_q    <= 1'b0;
            busy_q       <= 1'b0;
            clean_prev_q <= 1'b0;
        end else begin
            clean_prev_q <= btn_clean;
            case (state_q)
                IDLE: begin
                    if (press) begin
                        state_q   <= PENDING;
                        request_q <= 1'b1;
                    end
                end
                PENDING: begin
                    if (bus.ack) begin
                        state_q   <= SERVICE;
                        request_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (!bus.ack) begin
                        state_q  <= HOLDOFF;
                        ho_cnt_q <= HO_LOAD;
                    end
                end
                HOLDOFF: begin
                    // A press coinciding with the last hold-off cycle is
                    // honoured; earlier ones are dropped.
                    if (ho_cnt_q == '0) begin
                        busy_q <= 1'b0;
                        if (press) begin
                            state_q   <= PENDING;
                            request_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        ho_cnt_q <= ho_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    request_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.request   = request_q;
    assign bus.busy      = busy_q;
    assign bus.btn_clean = btn_clean;

`ifdef PED_REQ_COUNT_EN
    logic                   accept;
    logic [REQ_COUNT_W-1:0] req_count_q;

    assign accept = press && ((state_q == IDLE) || ho_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_count_q <= '0;
        end else if (accept && (req_count_q != '1)) begin
            req_count_q <= req_count_q + 1'b1;
        end
    end

    assign bus.req_count = req_count_q;
`endif

endmodule
`default_nettype wire
